// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
//
// Bundles the request, response and data-memory signals of the load/store
// initiator.
//   master modport : the lsu_mem_master side (drives req_ready, resp_*, mem_*
//                    strobes/addresses/write data; samples req_* and
//                    mem_read_data)
//   slave modport  : the pipeline + memory side (the opposite directions)
//
// Request  : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata, req_rd
// Response : resp_valid, resp_data, resp_rd, resp_err
// Memory   : mem_read_ready, mem_read_address, mem_read_data,
//            mem_write_ready, mem_write_address, mem_write_data, mem_write_byte
// -----------------------------------------------------------------------------
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;

   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;

   logic        mem_read_ready;
   logic [29:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic        mem_write_ready;
   logic [29:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_byte;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      input  mem_read_data,
      output req_ready,
      output resp_valid, resp_data, resp_rd, resp_err,
      output mem_read_ready, mem_read_address,
      output mem_write_ready, mem_write_address, mem_write_data, mem_write_byte
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      output mem_read_data,
      input  req_ready,
      input  resp_valid, resp_data, resp_rd, resp_err,
      input  mem_read_ready, mem_read_address,
      input  mem_write_ready, mem_write_address, mem_write_data, mem_write_byte
   );
endinterface

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store initiator for the memory stage. Accepts one RV32I load or store
// at a time and drives a word-addressed, byte-enabled, synchronous-read RAM.
// Stores: one write-strobe cycle with byte enables and lane-replicated data,
// completed in the same cycle. Loads: one read-strobe cycle, LOAD_LATENCY wait
// cycles, then the extracted and extended word is returned with its tag.
//
// Ports
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : lsu_mem_master_if.master (request / response / memory signals)
//
// Parameters
//   LOAD_LATENCY : cycles from the read-strobe cycle to valid read data (1-4)
//
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned halfword/word requests issue
//                      no strobe and complete next cycle with resp_err=1 and
//                      resp_data = faulting address. When undefined the low
//                      address bits are ignored for those sizes and
//                      resp_err is tied to 0.
// -----------------------------------------------------------------------------
module lsu_mem_master #(
   parameter int unsigned LOAD_LATENCY = 1
) (
   input logic              clk,
   input logic              reset,
   lsu_mem_master_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   // The counter is loaded when leaving ISSUE and WAIT ends when it reads 0,
   // so WAIT lasts exactly LOAD_LATENCY cycles.
   localparam logic [1:0] CNT_INIT = 2'(LOAD_LATENCY - 1);

   state_t      state_q;
   logic [1:0]  cnt_q;

   // Fields latched on accept
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [4:0]  rd_q;
   logic [29:0] addr_q;

   // Registered outputs
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic [4:0]  resp_rd_q;
   logic        rd_stb_q;
   logic        wr_stb_q;
   logic [31:0] wdata_q;
   logic [3:0]  wbyte_q;

   // Combinational helpers
   logic [3:0]  st_byte;
   logic [31:0] st_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_result;

   // ---------------------------------------------------------------------------
   // Store byte enables and lane-replicated data from the incoming request.
   // funct3[1:0]=3 falls into the word case.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      st_byte = 4'hF;
      st_data = bus.req_wdata;
      case (bus.req_funct3[1:0])
         2'd0: begin
            st_byte = 4'b0001 << bus.req_addr[1:0];
            st_data = {4{bus.req_wdata[7:0]}};
         end
         2'd1: begin
            // addr[0] is dropped: the halfword lane is forced aligned
            st_byte = 4'b0011 << {bus.req_addr[1], 1'b0};
            st_data = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Load extraction from the read word using the latched lane and funct3.
   // funct3[2] selects zero extension; funct3[1:0] of 2 or 3 is a full word.
   // ---------------------------------------------------------------------------
   always_comb begin
      ld_byte   = bus.mem_read_data[7:0];
      ld_half   = lane_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
      ld_result = bus.mem_read_data;
      case (lane_q)
         2'd0: ld_byte = bus.mem_read_data[7:0];
         2'd1: ld_byte = bus.mem_read_data[15:8];
         2'd2: ld_byte = bus.mem_read_data[23:16];
         2'd3: ld_byte = bus.mem_read_data[31:24];
      endcase
      case (f3_q[1:0])
         2'd0: ld_result = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'd1: ld_result = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_result = bus.mem_read_data;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   logic resp_err_q;

   always_comb begin
      misaligned = 1'b0;
      case (bus.req_funct3[1:0])
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = bus.req_addr[0];
         default: misaligned = |bus.req_addr[1:0];
      endcase
   end

   assign bus.resp_err = resp_err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         f3_q         <= '0;
         lane_q       <= '0;
         rd_q         <= '0;
         addr_q       <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
         rd_stb_q     <= 1'b0;
         wr_stb_q     <= 1'b0;
         wdata_q      <= '0;
         wbyte_q      <= '0;
`ifdef MISALIGN_TRAP_EN
         resp_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  f3_q        <= bus.req_funct3;
                  lane_q      <= bus.req_addr[1:0];
                  rd_q        <= bus.req_rd;
                  addr_q      <= bus.req_addr[31:2];
`ifdef MISALIGN_TRAP_EN
                  if (misaligned) begin
                     // Complete next cycle with the fault, no memory access
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= bus.req_addr;
                     resp_rd_q    <= bus.req_rd;
                  end else
`endif
                  if (bus.req_we) begin
                     // A store completes in its strobe cycle
                     state_q      <= STORE;
                     wr_stb_q     <= 1'b1;
                     wdata_q      <= st_data;
                     wbyte_q      <= st_byte;
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= '0;
                     resp_rd_q    <= '0;
                  end else begin
                     state_q  <= ISSUE;
                     rd_stb_q <= 1'b1;
                  end
               end else begin
                  // Also covers the first cycle out of reset
                  req_ready_q <= 1'b1;
               end
            end

            STORE: begin
               wr_stb_q     <= 1'b0;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end

            ISSUE: begin
               rd_stb_q <= 1'b0;
               cnt_q    <= CNT_INIT;
               state_q  <= WAIT;
            end

            WAIT: begin
               if (cnt_q == 2'd0) begin
                  // Read data is valid in this last WAIT cycle
                  resp_data_q  <= ld_result;
                  resp_rd_q    <= rd_q;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end

            RESP: begin
               resp_valid_q <= 1'b0;
               resp_data_q  <= '0;
               resp_rd_q    <= '0;
`ifdef MISALIGN_TRAP_EN
               resp_err_q   <= 1'b0;
`endif
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Both addresses come from one latched register and hold between requests
   assign bus.req_ready         = req_ready_q;
   assign bus.resp_valid        = resp_valid_q;
   assign bus.resp_data         = resp_data_q;
   assign bus.resp_rd           = resp_rd_q;
   assign bus.mem_read_ready    = rd_stb_q;
   assign bus.mem_read_address  = addr_q;
   assign bus.mem_write_ready   = wr_stb_q;
   assign bus.mem_write_address = addr_q;
   assign bus.mem_write_data    = wdata_q;
   assign bus.mem_write_byte    = wbyte_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
//
// Directed bench for lsu_mem_master. Two instances: u_dut1 with
// LOAD_LATENCY=1 and u_dut3 with LOAD_LATENCY=3, each attached to a small
// byte-enabled synchronous-read RAM whose read latency matches its instance.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   lsu_mem_master_if bus1 ();
   lsu_mem_master_if bus3 ();

   lsu_mem_master #(.LOAD_LATENCY(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.master)
   );

   lsu_mem_master #(.LOAD_LATENCY(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.master)
   );

   // ---------------------------------------------------------------------------
   // Memories: word index = address[7:0]
   // ---------------------------------------------------------------------------
   logic [31:0] mem1 [0:255];
   logic [31:0] rp1;
   logic [31:0] mem3 [0:255];
   logic [31:0] rp3 [0:2];

   always @(posedge clk) begin
      if (bus1.mem_write_ready === 1'b1)
         for (int b = 0; b < 4; b++)
            if (bus1.mem_write_byte[b])
               mem1[bus1.mem_write_address[7:0]][8*b +: 8] <= bus1.mem_write_data[8*b +: 8];
      if (bus1.mem_read_ready === 1'b1)
         rp1 <= mem1[bus1.mem_read_address[7:0]];
   end
   assign bus1.mem_read_data = rp1;

   always @(posedge clk) begin
      if (bus3.mem_write_ready === 1'b1)
         for (int b = 0; b < 4; b++)
            if (bus3.mem_write_byte[b])
               mem3[bus3.mem_write_address[7:0]][8*b +: 8] <= bus3.mem_write_data[8*b +: 8];
      if (bus3.mem_read_ready === 1'b1)
         rp3[0] <= mem3[bus3.mem_read_address[7:0]];
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end
   assign bus3.mem_read_data = rp3[2];

   // Read and write strobes must never coincide
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         checks++;
         if ((bus1.mem_read_ready & bus1.mem_write_ready) === 1'b1 ||
             (bus3.mem_read_ready & bus3.mem_write_ready) === 1'b1) begin
            errors++;
            $display("FAIL strobe_overlap at cycle %0d: both strobes high", cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [137:0] outs1();
      return {bus1.req_ready, bus1.resp_valid, bus1.resp_data, bus1.resp_rd, bus1.resp_err,
              bus1.mem_read_ready, bus1.mem_read_address, bus1.mem_write_ready,
              bus1.mem_write_address, bus1.mem_write_data, bus1.mem_write_byte};
   endfunction

   function automatic logic [137:0] outs3();
      return {bus3.req_ready, bus3.resp_valid, bus3.resp_data, bus3.resp_rd, bus3.resp_err,
              bus3.mem_read_ready, bus3.mem_read_address, bus3.mem_write_ready,
              bus3.mem_write_address, bus3.mem_write_data, bus3.mem_write_byte};
   endfunction

   // ---------------------------------------------------------------------------
   // Request drivers. Called on a falling edge; return on the falling edge of
   // cycle T+1 with req_valid dropped. acc is the cycle number seen at T+1.
   // ---------------------------------------------------------------------------
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, output int acc);
      int n = 0;
      bus1.req_we     = we;
      bus1.req_funct3 = f3;
      bus1.req_addr   = addr;
      bus1.req_wdata  = wdata;
      bus1.req_rd     = rd;
      bus1.req_valid  = 1'b1;
      while (bus1.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, wanted 1", bus1.req_ready, n);
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      bus1.req_valid = 1'b0;
   endtask

   task automatic do_req3(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
      int n = 0;
      bus3.req_we     = we;
      bus3.req_funct3 = f3;
      bus3.req_addr   = addr;
      bus3.req_wdata  = wdata;
      bus3.req_rd     = rd;
      bus3.req_valid  = 1'b1;
      while (bus3.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL req_ready3_timeout: req_ready=%b after %0d cycles, wanted 1", bus3.req_ready, n);
      end
      @(posedge clk);
      @(negedge clk);
      bus3.req_valid = 1'b0;
   endtask

   // From the T+1 falling edge, count cycles until resp_valid (T+1 counts as 1)
   task automatic wait_resp(output int lat);
      lat = 1;
      while (bus1.resp_valid !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs1() !== '0) begin
         errors++;
         $display("FAIL reset_outputs1: got %h wanted 0", outs1());
      end
      checks++;
      if (outs3() !== '0) begin
         errors++;
         $display("FAIL reset_outputs3: got %h wanted 0", outs3());
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_after_reset: got %b/%b wanted 1/1", bus1.req_ready, bus3.req_ready);
      end
   endtask

   task automatic test_store();
      int acc;
      do_req(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, acc);
      checks++;
      if ({bus1.mem_write_ready, bus1.mem_read_ready, bus1.mem_write_address, bus1.mem_write_byte}
          !== {1'b1, 1'b0, 30'h40, 4'hF}) begin
         errors++;
         $display("FAIL sw_strobe: wr=%b rd=%b addr=%h byte=%h wanted 1 0 40 f",
                  bus1.mem_write_ready, bus1.mem_read_ready, bus1.mem_write_address, bus1.mem_write_byte);
      end
      checks++;
      if (bus1.mem_write_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL sw_data: got %h wanted deadbeef", bus1.mem_write_data);
      end
      checks++;
      if ({bus1.resp_valid, bus1.resp_rd, bus1.resp_data} !== {1'b1, 5'd0, 32'h0}) begin
         errors++;
         $display("FAIL sw_resp: valid=%b rd=%0d data=%h wanted 1 0 0",
                  bus1.resp_valid, bus1.resp_rd, bus1.resp_data);
      end
      @(negedge clk);
      checks++;
      if ({bus1.mem_write_ready, bus1.resp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL sw_single_pulse: wr=%b valid=%b wanted 0 0", bus1.mem_write_ready, bus1.resp_valid);
      end
      checks++;
      if (bus1.mem_write_address !== 30'h40) begin
         errors++;
         $display("FAIL addr_hold: got %h wanted 40", bus1.mem_write_address);
      end

      do_req(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 5'd0, acc);
      checks++;
      if ({bus1.mem_write_byte, bus1.mem_write_data} !== {4'b1000, 32'hA5A5_A5A5}) begin
         errors++;
         $display("FAIL sb: byte=%b data=%h wanted 1000 a5a5a5a5", bus1.mem_write_byte, bus1.mem_write_data);
      end
      @(negedge clk);

      do_req(1'b1, 3'd1, 32'h0000_0102, 32'hFFFF_1234, 5'd0, acc);
      checks++;
      if ({bus1.mem_write_byte, bus1.mem_write_data} !== {4'b1100, 32'h1234_1234}) begin
         errors++;
         $display("FAIL sh: byte=%b data=%h wanted 1100 12341234", bus1.mem_write_byte, bus1.mem_write_data);
      end
      @(negedge clk);
   endtask

   task automatic test_load_extract();
      logic [2:0]  f3v  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] av   [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
      logic [31:0] ev   [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
      int acc;
      int lat;
      do_req(1'b1, 3'd2, 32'h0000_0100, 32'h80FF_7F01, 5'd0, acc);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3v[i], av[i], 32'h0, 5'(i + 1), acc);
         checks++;
         if ({bus1.mem_read_ready, bus1.mem_read_address} !== {1'b1, 30'h40}) begin
            errors++;
            $display("FAIL load%0d_issue: rd=%b addr=%h wanted 1 40", i, bus1.mem_read_ready, bus1.mem_read_address);
         end
         wait_resp(lat);
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL load%0d_latency: got %0d wanted 3", i, lat);
         end
         checks++;
         if ({bus1.resp_data, bus1.resp_rd, bus1.resp_err} !== {ev[i], 5'(i + 1), 1'b0}) begin
            errors++;
            $display("FAIL load%0d_result: data=%h rd=%0d err=%b wanted %h %0d 0",
                     i, bus1.resp_data, bus1.resp_rd, bus1.resp_err, ev[i], i + 1);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_latency3();
      logic [6:1] rr;
      logic [6:1] rv;
      logic [6:1] rq;
      logic [31:0] d;
      logic [4:0]  r;
      d = 'x;
      r = 'x;
      do_req3(1'b1, 3'd2, 32'h0000_0300, 32'hCAFE_F00D, 5'd0);
      do_req3(1'b0, 3'd2, 32'h0000_0300, 32'h0, 5'd7);
      for (int i = 1; i <= 6; i++) begin
         rr[i] = bus3.mem_read_ready;
         rv[i] = bus3.resp_valid;
         rq[i] = bus3.req_ready;
         if (bus3.resp_valid === 1'b1) begin
            d = bus3.resp_data;
            r = bus3.resp_rd;
         end
         if (i < 6) @(negedge clk);
      end
      checks++;
      if (rr !== 6'b000001) begin
         errors++;
         $display("FAIL lat3_read_strobe: cycles T+6..T+1 = %b wanted 000001", rr);
      end
      checks++;
      if (rv !== 6'b010000) begin
         errors++;
         $display("FAIL lat3_resp_valid: cycles T+6..T+1 = %b wanted 010000", rv);
      end
      checks++;
      if (rq !== 6'b100000) begin
         errors++;
         $display("FAIL lat3_req_ready: cycles T+6..T+1 = %b wanted 100000", rq);
      end
      checks++;
      if ({d, r} !== {32'hCAFE_F00D, 5'd7}) begin
         errors++;
         $display("FAIL lat3_result: data=%h rd=%0d wanted cafef00d 7", d, r);
      end
   endtask

   task automatic test_back_to_back();
      int acc_st;
      int acc_ld;
      int lat;
      do_req(1'b1, 3'd2, 32'h0000_0200, 32'h1234_5678, 5'd0, acc_st);
      do_req(1'b0, 3'd2, 32'h0000_0200, 32'h0, 5'd11, acc_ld);
      checks++;
      if (acc_ld - acc_st !== 2) begin
         errors++;
         $display("FAIL b2b_accept_gap: got %0d wanted 2", acc_ld - acc_st);
      end
      wait_resp(lat);
      checks++;
      if ({bus1.resp_valid, bus1.resp_data, bus1.resp_rd} !== {1'b1, 32'h1234_5678, 5'd11}) begin
         errors++;
         $display("FAIL b2b_load: valid=%b data=%h rd=%0d wanted 1 12345678 11",
                  bus1.resp_valid, bus1.resp_data, bus1.resp_rd);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      int  acc;
      logic seen;
      do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd3, acc);
      @(negedge clk);              // cycle T+2: WAIT
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (outs1() !== '0) begin
         errors++;
         $display("FAIL reset_in_wait_outputs: got %h wanted 0", outs1());
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus1.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_wait_ready: got %b wanted 1", bus1.req_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (bus1.resp_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait_no_resp: resp_valid seen=%b wanted 0", seen);
      end
   endtask

   task automatic test_misalign();
      int acc;
`ifdef MISALIGN_TRAP_EN
      do_req(1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd9, acc);
      checks++;
      if ({bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd} !== {1'b1, 1'b1, 32'h102, 5'd9}) begin
         errors++;
         $display("FAIL trap_lw: valid=%b err=%b data=%h rd=%0d wanted 1 1 102 9",
                  bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd);
      end
      checks++;
      if ({bus1.mem_read_ready, bus1.mem_write_ready} !== 2'b00) begin
         errors++;
         $display("FAIL trap_lw_strobe: rd=%b wr=%b wanted 0 0", bus1.mem_read_ready, bus1.mem_write_ready);
      end
      @(negedge clk);
      checks++;
      if ({bus1.mem_read_ready, bus1.resp_valid, bus1.resp_err} !== 3'b000) begin
         errors++;
         $display("FAIL trap_lw_after: rd=%b valid=%b err=%b wanted 0 0 0",
                  bus1.mem_read_ready, bus1.resp_valid, bus1.resp_err);
      end
      do_req(1'b1, 3'd1, 32'h0000_0101, 32'h5555, 5'd6, acc);
      checks++;
      if ({bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd, bus1.mem_write_ready}
          !== {1'b1, 1'b1, 32'h101, 5'd6, 1'b0}) begin
         errors++;
         $display("FAIL trap_sh: valid=%b err=%b data=%h rd=%0d wr=%b wanted 1 1 101 6 0",
                  bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd, bus1.mem_write_ready);
      end
      @(negedge clk);
`else
      int lat;
      do_req(1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd9, acc);
      wait_resp(lat);
      checks++;
      if ({bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd} !== {1'b1, 1'b0, 32'h80FF_7F01, 5'd9}) begin
         errors++;
         $display("FAIL aligned_lw: valid=%b err=%b data=%h rd=%0d wanted 1 0 80ff7f01 9",
                  bus1.resp_valid, bus1.resp_err, bus1.resp_data, bus1.resp_rd);
      end
      do_req(1'b0, 3'd1, 32'h0000_0103, 32'h0, 5'd6, acc);
      wait_resp(lat);
      checks++;
      if ({bus1.resp_valid, bus1.resp_err, bus1.resp_data} !== {1'b1, 1'b0, 32'hFFFF_80FF}) begin
         errors++;
         $display("FAIL aligned_lh: valid=%b err=%b data=%h wanted 1 0 ffff80ff",
                  bus1.resp_valid, bus1.resp_err, bus1.resp_data);
      end
      @(negedge clk);
`endif
   endtask

   initial begin
      reset           = 1'b1;
      bus1.req_valid  = 1'b0;
      bus1.req_we     = 1'b0;
      bus1.req_funct3 = 3'd0;
      bus1.req_addr   = 32'h0;
      bus1.req_wdata  = 32'h0;
      bus1.req_rd     = 5'd0;
      bus3.req_valid  = 1'b0;
      bus3.req_we     = 1'b0;
      bus3.req_funct3 = 3'd0;
      bus3.req_addr   = 32'h0;
      bus3.req_wdata  = 32'h0;
      bus3.req_rd     = 5'd0;

      test_reset();
      test_store();
      test_load_extract();
      test_latency3();
      test_back_to_back();
      test_reset_in_wait();
      test_misalign();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the data-memory port (word-addressed, byte-enabled, synchronous-read RAM) on behalf of the pipeline's memory stage. It accepts one RV32I load/store request at a time and generates the word address, byte strobes and lane-replicated store data. For loads it waits out the memory read latency, then extracts, sign- or zero-extends and returns the result with its destination register tag.

Parameters:
LOAD_LATENCY, 1, cycles from the mem_read_ready cycle to valid mem_read_data (range 1-4)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination tag
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result; 0 for stores
resp_rd  out  5  tag of the completed request; 0 for stores
resp_err  out  1  misaligned-access flag
mem_read_ready  out  1  read strobe
mem_read_address  out  30  word address [31:2]
mem_read_data  in  32  read word
mem_write_ready  out  1  write strobe
mem_write_address  out  30  word address [31:2]
mem_write_data  out  32  lane-replicated store data
mem_write_byte  out  4  byte enables

Behaviour:
- All outputs are registered. Reset drives every output to 0, clears the latency counter, drives state to IDLE and discards any in-flight request; no resp_valid follows a reset. req_ready is 0 in the reset cycle and 1 in the first cycle after release.
- FSM states: IDLE, STORE, ISSUE, WAIT, RESP. req_ready=1 only in IDLE. Accept = req_valid & req_ready at a clock edge; the request fields are latched on accept.
- IDLE -> STORE on accept with req_we=1. IDLE -> ISSUE on accept with req_we=0.
- STORE (1 cycle): mem_write_ready=1, resp_valid=1, resp_rd=0, resp_data=0, then -> IDLE.
- ISSUE (1 cycle): mem_read_ready=1 -> WAIT.
- WAIT: lasts exactly LOAD_LATENCY cycles, counted with a down-counter. At the edge ending the last WAIT cycle, the extracted mem_read_data is registered into resp_data -> RESP.
- RESP (1 cycle): resp_valid=1, resp_rd=latched tag -> IDLE.
- Load latency: accept at edge T, resp_valid high in cycle T+2+LOAD_LATENCY.
- Store latency: strobe and resp_valid high in cycle T+1.
- mem_read_ready and mem_write_ready are never both 1 in the same cycle. Each strobe is high for exactly one cycle per request. Both addresses equal the latched req_addr[31:2] and hold between requests.
- Store masks: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << {addr[1],1'b0}; SW = 4'hF.
- Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - Loads with funct3 3/6/7 are treated as LW; stores with funct3[1:0]=3 are treated as SW.
- Misalignment with the macro off: ignore addr[0] for halfwords and addr[1:0] for words (lane forced aligned).
- A store followed immediately by a load to the same word returns the new data, because the write completes before the read is issued.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: misaligned requests (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) are accepted but issue no memory strobe. The FSM goes IDLE -> RESP directly, and in cycle T+1 drives resp_valid=1, resp_err=1, resp_data=req_addr, resp_rd=req_rd.
- Undefined: resp_err is constant 0 and the alignment rule above applies.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 during reset; req_ready=1 in the first cycle after release.
2. SW addr 0x100, wdata 0xDEADBEEF -> in cycle T+1: mem_write_ready=1, mem_write_address=0x40, mem_write_byte=4'hF, mem_write_data=0xDEADBEEF, resp_valid=1. Then SB addr 0x103, wdata 0xA5 -> byte 4'b1000, data 0xA5A5A5A5.
3. Memory word 0x80FF7F01 at 0x100 -> results:
   - LB 0x103 -> 0xFFFFFF80
   - LBU 0x103 -> 0x00000080
   - LH 0x102 -> 0xFFFF80FF
   - LHU 0x102 -> 0x000080FF
   - LW 0x100 -> 0x80FF7F01
   Each with resp_valid exactly 3 cycles after accept (LOAD_LATENCY=1) and resp_rd equal to the issued tag.
4. LOAD_LATENCY=3, LW with rd=7 -> mem_read_ready high only in T+1, resp_valid in T+5, req_ready=0 from T+1 to T+5.
5. SW 0x200=0x12345678 followed back-to-back by LW 0x200 -> load returns 0x12345678; no cycle has both strobes high.
6. Reset asserted in the WAIT state -> no resp_valid; IDLE with req_ready=1 after release. With MISALIGN_TRAP_EN: LW 0x102 -> resp_err=1, resp_data=0x102, no memory strobe.
